cobra_run_ctrl: RTL and testbench

COBRA_RUN_CTRL -- requirements
Module: cobra_run_ctrl

---
 rtl/cobra_run_ctrl.sv | 100 ++++++++++
 tb/tb_cobra_run_ctrl.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/cobra_run_ctrl.sv
// cobra_run_ctrl: debug run/halt/step controller with commit gating and a retired-cycle counter.
// Optional breakpoint comparator with step-over is enabled by defining COBRA_RUN_CTRL_BKPT_EN.
`default_nettype none

module cobra_run_ctrl (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        cmd_valid_i,
   input  logic [1:0]  cmd_i,
   output logic        cmd_ready_o,
   input  logic [31:0] pc_i,
   input  logic        bkpt_en_i,
   input  logic [31:0] bkpt_addr_i,
   output logic        commit_en_o,
   output logic [1:0]  state_o,
   output logic        halted_o,
   output logic        bkpt_hit_o,
   output logic [31:0] retired_o
);

   typedef enum logic [1:0] {
      S_HALT = 2'b00,
      S_RUN  = 2'b01,
      S_STEP = 2'b10
   } state_t;

   localparam logic [1:0] c_CMD_RUN  = 2'b01;
   localparam logic [1:0] c_CMD_HALT = 2'b10;
   localparam logic [1:0] c_CMD_STEP = 2'b11;

   state_t      r_state;
   logic [31:0] r_retired;
   logic        w_accept;
   logic        w_match;
   logic        w_commit;

   assign cmd_ready_o = ~rst_i & (r_state != S_STEP);
   assign w_accept    = cmd_valid_i & cmd_ready_o;
   assign w_commit    = ~rst_i & ((r_state == S_STEP) | ((r_state == S_RUN) & ~w_match));

`ifdef COBRA_RUN_CTRL_BKPT_EN
   logic r_first_run;
   logic r_bkpt_hit;

   // The first RUN cycle after HALT never matches, so execution resumes from a breakpoint PC.
   assign w_match = (r_state == S_RUN) & bkpt_en_i & (pc_i == bkpt_addr_i) & ~r_first_run;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_first_run <= 1'b0;
         r_bkpt_hit  <= 1'b0;
      end else begin
         r_first_run <= (r_state == S_HALT) & w_accept & (cmd_i == c_CMD_RUN);
         r_bkpt_hit  <= w_match;
      end
   end

   assign bkpt_hit_o = r_bkpt_hit;
`else
   logic w_unused_bkpt;
   assign w_unused_bkpt = bkpt_en_i ^ (^bkpt_addr_i) ^ (^pc_i);
   assign w_match       = 1'b0;
   assign bkpt_hit_o    = 1'b0;
`endif

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state   <= S_HALT;
         r_retired <= 32'd0;
      end else begin
         if (w_commit) begin
            r_retired <= r_retired + 32'd1;
         end
         case (r_state)
            S_HALT: begin
               if (w_accept && (cmd_i == c_CMD_RUN)) begin
                  r_state <= S_RUN;
               end else if (w_accept && (cmd_i == c_CMD_STEP)) begin
                  r_state <= S_STEP;
               end
            end
            S_RUN: begin
               if (w_match || (w_accept && ((cmd_i == c_CMD_HALT) || (cmd_i == c_CMD_STEP)))) begin
                  r_state <= S_HALT;
               end
            end
            S_STEP:  r_state <= S_HALT;
            default: r_state <= S_HALT;
         endcase
      end
   end

   assign commit_en_o = w_commit;
   assign state_o     = r_state;
   assign halted_o    = (r_state == S_HALT);
   assign retired_o   = r_retired;

endmodule

`default_nettype wire

// File: tb/tb_cobra_run_ctrl.sv
// tb_cobra_run_ctrl: directed self-checking bench for cobra_run_ctrl.
`default_nettype none

module tb_cobra_run_ctrl;

   localparam logic [1:0] c_NOP  = 2'b00;
   localparam logic [1:0] c_RUN  = 2'b01;
   localparam logic [1:0] c_HALT = 2'b10;
   localparam logic [1:0] c_STEP = 2'b11;

   logic        clk_i = 1'b0;
   logic        rst_i = 1'b1;
   logic        cmd_valid_i = 1'b0;
   logic [1:0]  cmd_i = 2'b00;
   logic        cmd_ready_o;
   logic [31:0] pc_i = 32'd0;
   logic        bkpt_en_i = 1'b0;
   logic [31:0] bkpt_addr_i = 32'd0;
   logic        commit_en_o;
   logic [1:0]  state_o;
   logic        halted_o;
   logic        bkpt_hit_o;
   logic [31:0] retired_o;

   int n_chk  = 0;
   int n_pass = 0;
   int n_commit;
   logic [31:0] exp_ret;

   cobra_run_ctrl dut (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .cmd_valid_i (cmd_valid_i),
      .cmd_i       (cmd_i),
      .cmd_ready_o (cmd_ready_o),
      .pc_i        (pc_i),
      .bkpt_en_i   (bkpt_en_i),
      .bkpt_addr_i (bkpt_addr_i),
      .commit_en_o (commit_en_o),
      .state_o     (state_o),
      .halted_o    (halted_o),
      .bkpt_hit_o  (bkpt_hit_o),
      .retired_o   (retired_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
   endtask

   task automatic tick;
      @(posedge clk_i);
      #1;
   endtask

   // Drive inputs just after an edge and let combinational outputs settle.
   task automatic drv(input logic v, input logic [1:0] c, input logic [31:0] pc);
      cmd_valid_i = v;
      cmd_i       = c;
      pc_i        = pc;
      #1;
   endtask

   initial begin
      // reset holds everything idle even with a command presented
      rst_i = 1'b1;
      drv(1'b1, c_RUN, 32'd0);
      chk("rst_ready", cmd_ready_o, 0);
      chk("rst_commit", commit_en_o, 0);
      tick; tick;
      chk("rst_state", state_o, 0);
      chk("rst_halted", halted_o, 1);
      chk("rst_retired", retired_o, 0);
      chk("rst_hit", bkpt_hit_o, 0);

      rst_i = 1'b0;
      drv(1'b0, c_NOP, 32'd0);
      repeat (5) tick;
      chk("idle_state", state_o, 0);
      chk("idle_halted", halted_o, 1);
      chk("idle_commit", commit_en_o, 0);
      chk("idle_retired", retired_o, 0);
      chk("idle_ready", cmd_ready_o, 1);

      // RUN for 10 commit cycles, the last one carrying the HALT command
      drv(1'b1, c_RUN, 32'd0);
      chk("halt_nocommit", commit_en_o, 0);
      tick;
      chk("run_state", state_o, 1);
      chk("run_halted", halted_o, 0);
      n_commit = 0;
      for (int i = 0; i < 10; i++) begin
         drv(i == 9, (i == 9) ? c_HALT : c_NOP, 32'd0);
         n_commit += int'(commit_en_o);
         tick;
      end
      chk("run_ncommit", n_commit, 10);
      chk("run_retired", retired_o, 10);
      chk("run_halt_state", state_o, 0);
      drv(1'b0, c_NOP, 32'd0);
      chk("halted_commit", commit_en_o, 0);

      // command changes without valid, and an accepted NOP, do nothing
      drv(1'b0, c_RUN, 32'd0);
      tick;
      chk("novalid_state", state_o, 0);
      drv(1'b1, c_NOP, 32'd0);
      tick;
      chk("nop_state", state_o, 0);
      chk("nop_retired", retired_o, 10);

      // two STEPs with valid held high
      drv(1'b1, c_STEP, 32'd0);
      tick;
      chk("step1_state", state_o, 2);
      chk("step1_ready", cmd_ready_o, 0);
      chk("step1_commit", commit_en_o, 1);
      tick;
      chk("step_gap_state", state_o, 0);
      chk("step_gap_commit", commit_en_o, 0);
      tick;
      chk("step2_state", state_o, 2);
      chk("step2_commit", commit_en_o, 1);
      drv(1'b0, c_NOP, 32'd0);
      tick;
      chk("step_end_state", state_o, 0);
      chk("step_retired", retired_o, 12);

`ifdef COBRA_RUN_CTRL_BKPT_EN
      bkpt_addr_i = 32'h10;
      bkpt_en_i   = 1'b1;
      drv(1'b1, c_RUN, 32'd0);
      tick;
      for (int k = 0; k < 4; k++) begin
         drv(1'b0, c_NOP, 32'(4 * k));
         chk("bk_pre_commit", commit_en_o, 1);
         tick;
      end
      drv(1'b0, c_NOP, 32'h10);
      chk("bk_match_commit", commit_en_o, 0);
      tick;
      chk("bk_state", state_o, 0);
      chk("bk_hit", bkpt_hit_o, 1);
      chk("bk_retired", retired_o, 16);
      tick;
      chk("bk_hit_once", bkpt_hit_o, 0);

      // step-over on resume; a RUN accepted in RUN must not re-arm it
      drv(1'b1, c_RUN, 32'h10);
      tick;
      drv(1'b1, c_RUN, 32'h10);
      chk("bk_stepover", commit_en_o, 1);
      tick;
      drv(1'b0, c_NOP, 32'h10);
      chk("bk_no_rearm", commit_en_o, 0);
      tick;
      chk("bk_rearm_state", state_o, 0);
      chk("bk_rearm_hit", bkpt_hit_o, 1);
      chk("bk_rearm_ret", retired_o, 17);

      // HALT command coincident with a match
      drv(1'b1, c_RUN, 32'h10);
      tick;
      drv(1'b0, c_NOP, 32'h10);
      chk("bk_so2", commit_en_o, 1);
      tick;
      drv(1'b1, c_HALT, 32'h10);
      chk("bk_halt_match", commit_en_o, 0);
      tick;
      chk("bk_hm_state", state_o, 0);
      chk("bk_hm_hit", bkpt_hit_o, 1);
      chk("bk_hm_ret", retired_o, 18);

      // breakpoints ignored in STEP
      drv(1'b1, c_STEP, 32'h10);
      tick;
      drv(1'b0, c_NOP, 32'h10);
      chk("bk_step_commit", commit_en_o, 1);
      tick;
      chk("bk_step_hit", bkpt_hit_o, 0);
      chk("bk_step_ret", retired_o, 19);
      exp_ret = 32'd19;
`else
      bkpt_addr_i = 32'h10;
      bkpt_en_i   = 1'b1;
      drv(1'b1, c_RUN, 32'h10);
      tick;
      drv(1'b0, c_NOP, 32'h10);
      chk("nb_commit1", commit_en_o, 1);
      tick;
      drv(1'b1, c_HALT, 32'h10);
      chk("nb_commit2", commit_en_o, 1);
      tick;
      chk("nb_hit", bkpt_hit_o, 0);
      chk("nb_state", state_o, 0);
      chk("nb_retired", retired_o, 14);
      exp_ret = 32'd14;
`endif
      bkpt_en_i = 1'b0;
      chk("pre_wrap_ret", retired_o, exp_ret);

      // counter wrap: preload near the top, then three commits
      dut.r_retired = 32'hFFFF_FFFE;
      drv(1'b1, c_RUN, 32'd0);
      tick;
      drv(1'b0, c_NOP, 32'd0);
      tick;
      chk("wrap_ff", retired_o, 32'hFFFF_FFFF);
      tick;
      chk("wrap_zero", retired_o, 32'h0);
      drv(1'b1, c_HALT, 32'd0);
      tick;
      chk("wrap_one", retired_o, 32'h1);
      chk("wrap_state", state_o, 0);

      // reset during RUN
      drv(1'b1, c_RUN, 32'd0);
      tick;
      drv(1'b0, c_NOP, 32'd0);
      tick;
      rst_i = 1'b1;
      drv(1'b1, c_STEP, 32'd0);
      chk("rrun_commit", commit_en_o, 0);
      chk("rrun_ready", cmd_ready_o, 0);
      tick;
      chk("rrun_state", state_o, 0);
      chk("rrun_retired", retired_o, 0);
      rst_i = 1'b0;
      drv(1'b0, c_NOP, 32'd0);
      chk("rrun_after_commit", commit_en_o, 0);

      // reset during STEP
      drv(1'b1, c_STEP, 32'd0);
      tick;
      rst_i = 1'b1;
      drv(1'b0, c_NOP, 32'd0);
      chk("rstep_commit", commit_en_o, 0);
      tick;
      chk("rstep_state", state_o, 0);
      chk("rstep_retired", retired_o, 0);
      rst_i = 1'b0;
      tick;

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

`default_nettype wire
